display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Time-shares the two-digit 7-segment decoder between N_REQ requesters. The decoder takes a 4-bit data input and an active-low enable.
- Round-robin arbitration with a fixed hold time per slot and a blanking gap between slots.
- Drives the decoder's data and enable inputs directly. Sits between the game/status logic and the decoder.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- HOLD_CYCLES, 50000000, clock cycles a granted value is shown
- GAP_CYCLES, 5000000, blank cycles after each slot (>=1)
- BLINK_HALF, 12500000, half-period of blink in cycles (DISP_BLINK_EN only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  request per requester, level
- req_data  in  4*N_REQ  value of requester i on bits [4i+3:4i]
- alert  in  N_REQ  blink request per requester (present only with DISP_BLINK_EN)
- data  out  4  value to decoder data input
- disp_en_n  out  1  to decoder enable; 0 = show, 1 = blank
- owner  out  $clog2(N_REQ)  index of current/last granted requester
- ack  out  N_REQ  one-cycle pulse, slot of requester i completed
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Async reset (rst_n low) values:
  - State IDLE; data=0; disp_en_n=1; owner=0; ack=0; busy=0; timer=0.
  - Internal last pointer = N_REQ-1, so requester 0 wins first.
- States: IDLE, SHOW, GAP.
- IDLE:
  - If req != 0, the winner is the first set bit scanning circularly from (last+1) mod N_REQ.
  - Next cycle: state=SHOW, owner=winner, data=req_data[winner] latched (held stable for the whole slot), disp_en_n=0, timer=0.
  - If req == 0, stay in IDLE with disp_en_n=1 and data unchanged.
- SHOW:
  - Timer increments each cycle; SHOW lasts exactly HOLD_CYCLES cycles.
  - On the last SHOW cycle (timer=HOLD_CYCLES-1), next cycle: state=GAP, ack[owner]=1 for that one cycle, last=owner, disp_en_n=1, timer=0.
  - Early release: if req[owner]=0 on any SHOW cycle other than the last, next cycle goes to GAP with ack=0 and last=owner.
  - Simultaneous case: req[owner] dropping on the last SHOW cycle counts as completion, so ack is issued.
  - Changes on req_data or other req bits during SHOW are ignored.
- GAP:
  - disp_en_n=1 for exactly GAP_CYCLES cycles, then IDLE.
  - Arbitration happens in the IDLE cycle, so a continuous requester sees GAP_CYCLES+1 blank cycles between slots.
- Latency:
  - req rising in IDLE at cycle t gives data valid and disp_en_n=0 at cycle t+1.
  - busy=1 in SHOW and GAP.
- Timer width is $clog2(max(HOLD_CYCLES,GAP_CYCLES,BLINK_HALF)+1). The timer never wraps; it is cleared on every state change.
- Reset mid-operation: immediate return to reset values. No ack is issued and the last pointer is reset.
- ack is never asserted for more than one bit or more than one cycle per slot.

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined:
  - alert port exists.
  - During SHOW with alert[owner]=1, disp_en_n toggles every BLINK_HALF cycles, starting at 0 on the first SHOW cycle. The phase counter restarts at each grant.
  - alert sampled 0 forces disp_en_n=0 on the next cycle and restarts the phase.
  - Slot length and ack timing are unchanged.
- Not defined: no alert port; disp_en_n is constantly 0 throughout SHOW.

Test Plan:
- All tests use N_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=2, BLINK_HALF=2.
- Reset: rst_n=0 mid-clock -> outputs take reset values immediately without a clock edge: data=0, disp_en_n=1, ack=0, busy=0, owner=0.
- Single request: req=0001 and req_data[3:0]=4'hA at cycle 0 -> cycles 1-8 data=A, disp_en_n=0, owner=0; cycle 9 ack=0001, disp_en_n=1; cycles 9-10 GAP; cycle 11 IDLE; cycle 12 SHOW again if req held.
- Round robin: req=1111 held, data values 3,7,C,F -> owner sequence 0,1,2,3,0 with data 3,7,C,F,3; one ack pulse per slot in matching bit order.
- Early drop: req=0100 granted, req[2] drops at 4th SHOW cycle -> next cycle GAP, disp_en_n=1, ack stays 0; next grant scans from requester 3.
- Reset mid-SHOW: rst_n low during 5th SHOW cycle of owner 1, then released with req=0011 -> no ack pulse; the next grant after reset goes to requester 0.
- Blink (DISP_BLINK_EN): alert=0001 with req=0001 -> disp_en_n over the 8 SHOW cycles = 0,0,1,1,0,0,1,1; ack still at cycle 9.

Source files
------------

// File: rtl/display_scheduler.sv
// Purpose : round-robin time-sharing of one 7-segment decoder between N_REQ requesters.
// Latency : a request seen in IDLE is on the decoder on the next cycle; slot = HOLD_CYCLES, blank gap = GAP_CYCLES.
// Backpressure: none; requesters hold a level request, drop it to release early, and get a one-cycle ack on completion.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_req             level request per requester
//   i_req_data        4-bit value of requester i on bits [4i+3:4i]
//   i_alert           blink request per requester (only when DISP_BLINK_EN is defined)
//   o_data            value to the decoder data input, latched at grant
//   o_disp_en_n       decoder enable, 0 = show, 1 = blank
//   o_owner           index of the current / last granted requester
//   o_ack             one-cycle pulse on the bit of a requester whose slot ran to completion
//   o_busy            high whenever the scheduler is not idle
//
// Optional feature macro: DISP_BLINK_EN (adds i_alert and blinking of the shown value).

module display_scheduler #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int BLINK_HALF  = 12500000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [4*N_REQ-1:0]         i_req_data,
`ifdef DISP_BLINK_EN
    input  logic [N_REQ-1:0]           i_alert,
`endif
    output logic [3:0]                 o_data,
    output logic                       o_disp_en_n,
    output logic [$clog2(N_REQ)-1:0]   o_owner,
    output logic [N_REQ-1:0]           o_ack,
    output logic                       o_busy
);

    localparam int OW      = $clog2(N_REQ);
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > BLINK_HALF) ? MAX_HG : BLINK_HALF;
    localparam int TW      = $clog2(MAX_ALL + 1);

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
`ifdef DISP_BLINK_EN
    localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);
`endif
    // Last pointer starts at the top index so requester 0 is scanned first.
    localparam logic [OW-1:0] LAST_RST  = OW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_data;
    logic              r_disp_en_n;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_last;
    logic [N_REQ-1:0]  r_ack;
    logic              r_busy;
    logic [TW-1:0]     r_timer;
`ifdef DISP_BLINK_EN
    logic [TW-1:0]     r_blink_cnt;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: each requester's priority is its circular distance
    // from (last+1); the requesting index with the smallest distance wins.
    // Looping over constant indices keeps every select static.
    // ------------------------------------------------------------------
    logic              w_any;
    logic [OW-1:0]     w_winner;
    logic [3:0]        w_win_data;
    int                w_best;
    int                w_dist;

    assign w_any = |i_req;

    always_comb begin
        w_winner   = '0;
        w_win_data = '0;
        w_best     = N_REQ;
        w_dist     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 1 - int'(r_last)) % N_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_winner   = OW'(i);
                w_win_data = i_req_data[4*i +: 4];
            end
        end
    end

    // Owner's own request, used for early release; other bits are ignored in SHOW.
    logic w_owner_req;
    assign w_owner_req = i_req[r_owner];

`ifdef DISP_BLINK_EN
    logic w_owner_alert;
    assign w_owner_alert = i_alert[r_owner];
`endif

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_disp_en_n <= 1'b1;
            r_owner     <= '0;
            r_last      <= LAST_RST;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_timer     <= '0;
`ifdef DISP_BLINK_EN
            r_blink_cnt <= '0;
`endif
        end else begin
            // ack is a single-cycle pulse; only the SHOW completion sets it.
            r_ack <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_SHOW;
                        r_owner     <= w_winner;
                        r_data      <= w_win_data;
                        r_disp_en_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_timer     <= '0;
`ifdef DISP_BLINK_EN
                        r_blink_cnt <= '0;
`endif
                    end else begin
                        r_disp_en_n <= 1'b1;
                    end
                end

                ST_SHOW: begin
                    // Completion is checked before the release so that a
                    // request dropping on the final cycle still earns an ack.
                    if (r_timer == HOLD_LAST) begin
                        r_state        <= ST_GAP;
                        r_ack[r_owner] <= 1'b1;
                        r_last         <= r_owner;
                        r_disp_en_n    <= 1'b1;
                        r_timer        <= '0;
                    end else if (!w_owner_req) begin
                        r_state     <= ST_GAP;
                        r_last      <= r_owner;
                        r_disp_en_n <= 1'b1;
                        r_timer     <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
`ifdef DISP_BLINK_EN
                        // Blink phase: toggle every BLINK_HALF cycles while
                        // alert is held; a low alert shows steadily and
                        // restarts the phase.
                        if (!w_owner_alert) begin
                            r_disp_en_n <= 1'b0;
                            r_blink_cnt <= '0;
                        end else if (r_blink_cnt == BLINK_LAST) begin
                            r_disp_en_n <= ~r_disp_en_n;
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
`else
                        r_disp_en_n <= 1'b0;
`endif
                    end
                end

                ST_GAP: begin
                    r_disp_en_n <= 1'b1;
                    if (r_timer == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_disp_en_n <= 1'b1;
                    r_busy      <= 1'b0;
                    r_timer     <= '0;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_disp_en_n = r_disp_en_n;
    assign o_owner     = r_owner;
    assign o_ack       = r_ack;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed slot scenarios with literal expectations,
// then randomized requests/data/alerts/resets checked every cycle against a
// slot-level model (remaining show/gap cycles, circular scan, blink run length).

module tb_display_scheduler;

    localparam int N  = 4;
    localparam int H  = 8;
    localparam int G  = 2;
    localparam int B  = 2;
    localparam int OW = 2;
`ifdef DISP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic [N-1:0]   req      = '0;
    logic [4*N-1:0] req_data = '0;
    logic [N-1:0]   alert    = '0;

    logic [3:0]     data;
    logic           en_n;
    logic [OW-1:0]  owner;
    logic [N-1:0]   ack;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    display_scheduler #(
        .N_REQ       (N),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .BLINK_HALF  (B)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_req_data  (req_data),
`ifdef DISP_BLINK_EN
        .i_alert     (alert),
`endif
        .o_data      (data),
        .o_disp_en_n (en_n),
        .o_owner     (owner),
        .o_ack       (ack),
        .o_busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Slot-level reference model.
    // ------------------------------------------------------------------
    bit             m_in_show  = 1'b0;
    bit             m_in_gap   = 1'b0;
    int             m_show_left = 0;
    int             m_gap_left  = 0;
    int             m_last      = N - 1;
    int             m_run       = 0;
    logic [3:0]     e_data  = '0;
    logic           e_en_n  = 1'b1;
    int             e_owner = 0;
    logic [N-1:0]   e_ack   = '0;
    logic           e_busy  = 1'b0;

    function automatic int pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (((r >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_in_show = 1'b0; m_in_gap = 1'b0; m_show_left = 0; m_gap_left = 0;
        m_last = N - 1; m_run = 0;
        e_data = '0; e_en_n = 1'b1; e_owner = 0; e_ack = '0; e_busy = 1'b0;
    endtask

    task automatic leave_show();
        m_last = e_owner; m_in_show = 1'b0; m_in_gap = 1'b1;
        m_gap_left = G; e_en_n = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            e_ack = '0;
            if (m_in_show) begin
                m_show_left--;
                if (m_show_left == 0) begin
                    e_ack = N'(1 << e_owner);
                    leave_show();
                end else if (((req >> e_owner) & 1) == 0) begin
                    leave_show();
                end else begin
                    if (BLINK && (((alert >> e_owner) & 1) != 0)) m_run++;
                    else m_run = 0;
                    e_en_n = ((m_run / B) % 2) == 1;
                end
            end else if (m_in_gap) begin
                m_gap_left--;
                if (m_gap_left == 0) begin
                    m_in_gap = 1'b0;
                    e_busy   = 1'b0;
                end
            end else if (req != '0) begin
                e_owner     = pick(m_last, req);
                e_data      = 4'(req_data >> (4 * e_owner));
                m_in_show   = 1'b1;
                m_show_left = H;
                m_run       = 0;
                e_en_n      = 1'b0;
                e_busy      = 1'b1;
            end else begin
                e_en_n = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.data",  32'(data),  32'(e_data));
            chk("model.en_n",  32'(en_n),  32'(e_en_n));
            chk("model.owner", 32'(owner), 32'(e_owner));
            chk("model.ack",   32'(ack),   32'(e_ack));
            chk("model.busy",  32'(busy),  32'(e_busy));
        end
    end

    // Reset for one cycle; returns at negedge+1 with reset released, so the
    // next posedge is "cycle 0" of whatever the caller drives now.
    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; req = '0; alert = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] rr_vals [4];
`ifdef DISP_BLINK_EN
    logic       blink_pat [8];
`endif

    initial begin
        rr_vals = '{4'h3, 4'h7, 4'hC, 4'hF};

        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1;
        chk("reset.data",  32'(data),  32'h0);
        chk("reset.en_n",  32'(en_n),  32'h1);
        chk("reset.ack",   32'(ack),   32'h0);
        chk("reset.busy",  32'(busy),  32'h0);
        chk("reset.owner", 32'(owner), 32'h0);
        chk_en = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Single request.
        do_reset();
        req = 4'b0001; req_data = 16'h000A;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk("single.data",  32'(data),  32'hA);
                chk("single.en_n",  32'(en_n),  32'h0);
                chk("single.owner", 32'(owner), 32'h0);
            end
            if (c == 9) begin
                chk("single.ack9",  32'(ack),  32'h1);
                chk("single.blank9", 32'(en_n), 32'h1);
            end
            if (c == 10) chk("single.ack10", 32'(ack), 32'h0);
            if (c == 11) chk("single.idle11", 32'(busy), 32'h0);
            if (c == 12) chk("single.show12", 32'(en_n), 32'h0);
        end

        // Round robin over all four requesters.
        do_reset();
        req = 4'b1111; req_data = 16'hFC73;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            if ((c - 1) % 11 == 0) begin
                chk("rr.owner", 32'(owner), 32'(((c - 1) / 11) % 4));
                chk("rr.data",  32'(data),  32'(rr_vals[((c - 1) / 11) % 4]));
            end
            if ((c - 1) % 11 == 8)
                chk("rr.ack", 32'(ack), 32'(1 << (((c - 1) / 11) % 4)));
        end

        // Early drop on the 4th SHOW cycle.
        do_reset();
        req = 4'b0100; req_data = 16'h0500;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("drop.owner", 32'(owner), 32'h2);
                chk("drop.data",  32'(data),  32'h5);
                #1 req = 4'b0000;
            end
            if (c == 5) begin
                chk("drop.blank", 32'(en_n), 32'h1);
                chk("drop.ack",   32'(ack),  32'h0);
                chk("drop.busy",  32'(busy), 32'h1);
                #1 req = 4'b1111;
            end
            if (c == 6) chk("drop.ack6", 32'(ack), 32'h0);
            if (c == 8) chk("drop.next_owner", 32'(owner), 32'h3);
        end

        // Reset during the 5th SHOW cycle of requester 1.
        do_reset();
        req = 4'b0010; req_data = 16'h0094;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        chk("rst_mid.owner_before", 32'(owner), 32'h1);
        #1 rst_n = 1'b0; req = 4'b0011;
        #1;
        chk("rst_mid.data",  32'(data),  32'h0);
        chk("rst_mid.en_n",  32'(en_n),  32'h1);
        chk("rst_mid.busy",  32'(busy),  32'h0);
        chk("rst_mid.ack",   32'(ack),   32'h0);
        @(negedge clk);
        chk("rst_mid.ack_hold", 32'(ack), 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.regrant_owner", 32'(owner), 32'h0);
        chk("rst_mid.regrant_data",  32'(data),  32'h4);
        chk("rst_mid.regrant_ack",   32'(ack),   32'h0);

`ifdef DISP_BLINK_EN
        // Blink with alert held.
        blink_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        req = 4'b0001; alert = 4'b0001; req_data = 16'h000B;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 8) chk("blink.en_n", 32'(en_n), 32'(blink_pat[c - 1]));
            else        chk("blink.ack",  32'(ack),  32'h1);
        end
        alert = '0;
`endif

        // Randomized traffic; the compare process checks every cycle.
        do_reset();
        repeat (1500) begin
            @(negedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(199) == 0) rst_n = 1'b0;
            if ($urandom_range(7) == 0) req = 4'($urandom);
            req_data = 16'($urandom);
            if ($urandom_range(3) == 0) alert = 4'($urandom);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
